// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the timed arbiters.
// Holds the arbiter state encoding and the helper used to size the
// in-state timer so every arbiter in the family agrees on them.
package arb_pkg;

    localparam int ARB_STATE_W = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } arb_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Timer must be able to hold the largest terminal count (SLICE-1 or GAP-1)
    // plus one more value so the idle-state saturation has headroom.
    function automatic int timer_width(input int slice, input int gap);
        return $clog2(max2(slice, gap) + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   i_req  [N]  - request vector
//   i_last [IW] - index of the previous owner
//   o_pick [IW] - first requester found searching last+1, last+2, ... last
//   o_any       - at least one request is active
// When nobody requests, o_pick returns i_last; callers qualify with o_any.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_pick,
    output logic          o_any
);

    logic [IW-1:0] w_idx;

    always_comb begin
        o_pick = i_last;
        o_any  = |i_req;
        w_idx  = '0;
        // Walk from the farthest candidate back to the nearest so that the
        // nearest active requester (lowest offset from last) is written last.
        for (int k = N; k >= 1; k--) begin
            w_idx = IW'((int'(i_last) + k) % N);
            if (i_req[w_idx]) begin
                o_pick = w_idx;
            end
        end
    end

endmodule

// File: rtl/timed_rr_arbiter.sv
// timed_rr_arbiter: timer-driven round-robin arbiter for N requesters.
// Each grant lasts at most SLICE cycles, and GAP idle cycles separate grants.
// Outputs decode only from registers, so they never glitch.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no owner; waiting for any request
//   S_GRANT | r_cur owns the resource; timer counts grant cycles
//   S_GAP   | mandatory idle between owners; timer counts gap cycles
//
// Ports:
//   clk         - rising-edge clock
//   reset       - asynchronous active-high reset
//   req    [N]  - level requests, held until served
//   grant  [N]  - one-hot grant, zero when idle or in gap
//   grant_id    - owner index, zero when no grant
//   grant_valid - OR of grant
//   timeout     - one-cycle pulse: previous grant ended by slice expiry
module timed_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int SLICE = 8,
    parameter int GAP   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 grant_valid,
    output logic                 timeout
);

    localparam int IW = $clog2(N);
    localparam int TW = timer_width(SLICE, GAP);

    localparam logic [TW-1:0] T_SLICE_END = TW'(SLICE - 1);
    localparam logic [TW-1:0] T_GAP_END   = (GAP > 0) ? TW'(GAP - 1) : '0;
    // Starting at N-1 makes requester 0 the first in the round-robin search.
    localparam logic [IW-1:0] CUR_RESET   = IW'(N - 1);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [TW-1:0] r_t;
    logic [TW-1:0] w_t_nxt;
    logic [IW-1:0] r_cur;
    logic [IW-1:0] w_cur_nxt;
    logic          r_exp;
    logic          w_exp_nxt;

    logic [IW-1:0] w_pick;
    logic          w_any;
    logic          w_release;
    logic          w_expire;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_req  (req),
        .i_last (r_cur),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_cur   <= CUR_RESET;
            r_exp   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_cur   <= w_cur_nxt;
            r_exp   <= w_exp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_cur_nxt   = r_cur;
        // Expiry flag lives for exactly one cycle after it is set.
        w_exp_nxt   = 1'b0;
        w_release   = ~req[r_cur];
        w_expire    = (r_t == T_SLICE_END);

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                    w_cur_nxt   = w_pick;
                    w_t_nxt     = '0;
                end else if (r_t != '1) begin
                    w_t_nxt = r_t + TW'(1);
                end
            end

            S_GRANT: begin
                if (w_release || w_expire) begin
                    // Release wins when both happen in the same cycle.
                    w_exp_nxt = ~w_release;
                    w_t_nxt   = '0;
                    if (GAP > 0) begin
                        w_state_nxt = S_GAP;
                    end else if (w_any) begin
                        w_state_nxt = S_GRANT;
                        w_cur_nxt   = w_pick;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_t_nxt = r_t + TW'(1);
                end
            end

            S_GAP: begin
                if (r_t == T_GAP_END) begin
                    w_t_nxt = '0;
                    if (w_any) begin
                        w_state_nxt = S_GRANT;
                        w_cur_nxt   = w_pick;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_t_nxt = r_t + TW'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_t_nxt     = '0;
            end
        endcase
    end

    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        if (r_state == S_GRANT) begin
            grant[r_cur] = 1'b1;
            grant_id     = r_cur;
            grant_valid  = 1'b1;
        end
        // With GAP>0 the flag is only ever set on entry to S_GAP, so this is
        // the first gap cycle; with GAP=0 it lands on the following state.
        timeout = r_exp;
    end

endmodule

// File: tb/tb_timed_rr_arbiter.sv
module tb_timed_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] req;
        logic [7:0] exp;
    } ent_t;

    ent_t q[$];
    ent_t e;

    logic [7:0] obs;
    assign obs = {grant, grant_id, grant_valid, timeout};

    timed_rr_arbiter #(
        .N     (4),
        .SLICE (8),
        .GAP   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected word for a grant to requester id.
    function automatic logic [7:0] w_grant(input int id);
        logic [3:0] g;
        g = '0;
        g[id[1:0]] = 1'b1;
        return {g, id[1:0], 1'b1, 1'b0};
    endfunction

    // Expected word when no grant is active.
    function automatic logic [7:0] w_none(input logic to);
        return {4'b0000, 2'b00, 1'b0, to};
    endfunction

    task automatic push(input logic [3:0] r, input logic [7:0] x);
        q.push_back('{req: r, exp: x});
    endtask

    task automatic push_grants(input logic [3:0] r, input int id, input int n);
        for (int i = 0; i < n; i++) push(r, w_grant(id));
    endtask

    // Owner drops req: one release gap cycle (no timeout), then idle.
    task automatic push_tail();
        push(4'b0000, w_none(1'b0));
        push(4'b0000, w_none(1'b0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        req   = 4'b0000;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req   = 4'b0000;
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", obs, 8'h00);
        end
        reset = 1'b0;
        push(4'b0000, w_none(1'b0));
        push(4'b0000, w_none(1'b0));
        while (q.size() > 0) begin
            e = q.pop_front();
            req = e.req;
            @(posedge clk); #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL reset_idle: got %b want %b", obs, e.exp);
            end
        end
    endtask

    task automatic test_single_hold();
        push_grants(4'b0100, 2, 8);
        push(4'b0100, w_none(1'b1));
        push_grants(4'b0100, 2, 3);
        push_tail();
        while (q.size() > 0) begin
            e = q.pop_front();
            req = e.req;
            @(posedge clk); #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL single_hold: got %b want %b", obs, e.exp);
            end
        end
    endtask

    task automatic test_expiry_repeat();
        for (int i = 0; i < 30; i++) begin
            if ((i % 9) < 8) push(4'b0001, w_grant(0));
            else             push(4'b0001, w_none(1'b1));
        end
        push_tail();
        while (q.size() > 0) begin
            e = q.pop_front();
            req = e.req;
            @(posedge clk); #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL expiry_repeat: got %b want %b", obs, e.exp);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int id = 0; id < 4; id++) begin
            push_grants(4'b1111, id, 8);
            push(4'b1111, w_none(1'b1));
        end
        push_grants(4'b1111, 0, 8);
        // Dropping at t=7: release wins over expiry, so no timeout.
        push_tail();
        while (q.size() > 0) begin
            e = q.pop_front();
            req = e.req;
            @(posedge clk); #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL round_robin: got %b want %b", obs, e.exp);
            end
        end
    endtask

    task automatic test_early_release();
        push_grants(4'b1010, 1, 3);
        push(4'b1000, w_none(1'b0));
        push_grants(4'b1000, 3, 2);
        push_tail();
        while (q.size() > 0) begin
            e = q.pop_front();
            req = e.req;
            @(posedge clk); #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL early_release: got %b want %b", obs, e.exp);
            end
        end
    endtask

    task automatic test_drop_while_waiting();
        push_grants(4'b0011, 0, 2);
        push_grants(4'b0001, 0, 6);
        push(4'b0001, w_none(1'b1));
        push_grants(4'b0001, 0, 1);
        push_tail();
        while (q.size() > 0) begin
            e = q.pop_front();
            req = e.req;
            @(posedge clk); #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL drop_waiting: got %b want %b", obs, e.exp);
            end
        end
    endtask

    task automatic test_release_at_last();
        push_grants(4'b0100, 2, 8);
        push_tail();
        while (q.size() > 0) begin
            e = q.pop_front();
            req = e.req;
            @(posedge clk); #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL release_at_last: got %b want %b", obs, e.exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_grants(4'b1111, 0, 8);
        push(4'b1111, w_none(1'b1));
        push_grants(4'b1111, 1, 8);
        push(4'b1111, w_none(1'b1));
        push_grants(4'b1111, 2, 3);
        while (q.size() > 0) begin
            e = q.pop_front();
            req = e.req;
            @(posedge clk); #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL reset_mid_pre: got %b want %b", obs, e.exp);
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async: got %b want %b", obs, 8'h00);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        push_grants(4'b1111, 0, 2);
        push_tail();
        while (q.size() > 0) begin
            e = q.pop_front();
            req = e.req;
            @(posedge clk); #1;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL reset_mid_post: got %b want %b", obs, e.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_expiry_repeat();
        test_round_robin();
        test_early_release();
        test_drop_while_waiting();
        test_release_at_last();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
